// File: rtl/mcycle_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package mcycle_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic MCYCLE_OP_MUL = 1'b0;
    localparam logic MCYCLE_OP_DIV = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mcycle_step.sv
// One iteration of shift-add multiply or restoring divide.
module mcycle_step
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op,
    input  logic [WIDTH:0]   hi_rem,
    input  logic [WIDTH-1:0] lo_quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   hi_rem_nxt,
    output logic [WIDTH-1:0] lo_quo_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        sum     = hi_rem + (lo_quo[0] ? {1'b0, divisor} : '0);
        shifted = {hi_rem[WIDTH-1:0], lo_quo[WIDTH-1]};
        fits    = shifted >= {1'b0, divisor};
        diff    = shifted - {1'b0, divisor};
        if (op == MCYCLE_OP_MUL) begin
            // carry lands in hi's msb position after the right shift
            hi_rem_nxt = {1'b0, sum[WIDTH:1]};
            lo_quo_nxt = {sum[0], lo_quo[WIDTH-1:1]};
        end else if (fits) begin
            hi_rem_nxt = diff;
            lo_quo_nxt = {lo_quo[WIDTH-2:0], 1'b1};
        end else begin
            hi_rem_nxt = shifted;
            lo_quo_nxt = {lo_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle unsigned MUL/DIV responder: one bit per cycle,
// Busy stalls the pipeline, Done pulses with registered results.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic             op_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH:0]   hi_q, hi_nxt;
    logic [WIDTH-1:0] lo_q, lo_nxt;
    logic             last;
    logic             accept;

    assign last   = (count == LAST);
    assign accept = (state == IDLE) && Start;

    mcycle_step #(.WIDTH(WIDTH)) u_step (
        .op         (op_q),
        .hi_rem     (hi_q),
        .lo_quo     (lo_q),
        .divisor    (divisor_q),
        .hi_rem_nxt (hi_nxt),
        .lo_quo_nxt (lo_nxt)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (Start) state_nxt = COMPUTE;
            COMPUTE: if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Busy is gated by reset so a held Start cannot stall during reset
    always_comb begin
        Busy = RESETn && (accept || (state == COMPUTE));
        Done = (state == DONE);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            count     <= '0;
            op_q      <= 1'b0;
            divisor_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            Result1   <= '0;
            Result2   <= '0;
        end else if (accept) begin
            count     <= '0;
            op_q      <= MCycleOp;
            divisor_q <= Operand2;
            hi_q      <= '0;
            lo_q      <= Operand1;
        end else if (state == COMPUTE) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            if (last) begin
                Result1 <= lo_nxt;
                Result2 <= hi_nxt[WIDTH-1:0];
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule
